kf8237_bus_interface: RTL and testbench
=======================================

# kf8237_bus_interface

Parametrised host-bus front end for the KF8237 DMA controller family, generalised to 1–8 channels. Tracks complete CPU read/write accesses with abort-on-lock, and emits exactly one single-cycle command strobe per completed write. Owns the byte-pointer flip-flop and drives the read data bus from the channel and control registers. Sits between the CPU-side pins and the register/priority logic of the DMA core.

## Interface
Parameters:
- CHANNELS, 4, number of DMA channels, 1..8.
- AW, max($clog2(2*CHANNELS),3)+1, address width; derived, do not override.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- chip_select_n  in  1  device select.
- io_read_n_in  in  1  CPU read strobe.
- io_write_n_in  in  1  CPU write strobe.
- address_in  in  AW  register offset.
- data_bus_in  in  8  CPU write data.
- lock_bus_control  in  1  DMA owns bus; CPU accesses are aborted.
- current_address  in  16*CHANNELS  channel n at bits [16n+15:16n].
- current_word_count  in  16*CHANNELS  same packing.
- status_register, temporary_register  in  8 each.
- internal_data_bus  out  8  data latched from the last accepted write sample.
- write_command_register, write_request_register, set_or_reset_mask_register, write_mode_register, write_mask_register, master_clear, clear_mask_register  out  1 each  strobes.
- write_base_and_current_address, write_base_and_current_word_count  out  CHANNELS each  one-hot strobes.
- access_high_byte  out  1  byte-pointer value captured for the access that produced the current strobe.
- byte_pointer  out  1  live byte-pointer flip-flop.
- read_status_done  out  1  strobe when a status read completes (TC-bit clear).
- data_bus_out  out  8  read data.
- data_bus_out_enable  out  1  drive enable.

## Operation
- Offset map: MSB of address_in = 0 selects channel registers, offset 2n = address of channel n and 2n+1 = count of channel n; entries with n ≥ CHANNELS are ignored. MSB = 1 selects control; the low 3 bits decode as 0 command/status, 1 request, 2 single mask, 3 mode, 4 clear byte pointer (write) / set byte pointer (read), 5 master clear (write) / temporary (read), 6 clear mask, 7 write all mask.
- Access tracker, one instance each for read and write. Idle → ACTIVE when sampled ~strobe_n & ~chip_select_n. Stays in ACTIVE while that condition holds. Then → END for one cycle → Idle.
- A sticky abort flag is set if lock_bus_control is high on any sample while ACTIVE; an aborted access produces no strobes and no pointer change.
- Read and write both low on the same sample: that sample is inactive for both trackers, so any access in progress ends.
- Address and data are latched on every ACTIVE write sample. Decoding uses the last latched address.
- On a completed write: fire the decoded strobe. A channel-register write toggles byte_pointer. Offset 4 clears byte_pointer. Offset 5 (master_clear) clears byte_pointer.
- On a completed read: a channel-register read toggles byte_pointer. Offset 4 sets byte_pointer. Offset 0 fires read_status_done.
- data_bus_out is registered and updated every ACTIVE read sample. Channel registers return the low byte when byte_pointer = 0, else the high byte. Status and temporary are returned as-is. All other offsets return 8'hFF.
- data_bus_out_enable = read tracker ACTIVE and not aborted.

## Timing
- Reset: all strobes 0, internal_data_bus 8'h00, byte_pointer 0, access_high_byte 0, data_bus_out 8'hFF, data_bus_out_enable 0, trackers Idle, abort cleared.
- Reset mid-access discards the access; no strobe follows reset.
- Strobes are registered and high for exactly one cycle. The strobe is output in the cycle after the clock edge at which the ending (inactive) sample is taken.
- byte_pointer updates on that same edge, so during a strobe byte_pointer already holds the new value; access_high_byte holds the old value.
- Read data is valid one cycle after the first ACTIVE read sample.
- Back-to-back accesses need at least one inactive sample between them. Consecutive ACTIVE samples form one access.

## Structure
- Package kf8237_bus_pkg holds: offset constants (CTRL_COMMAND … CTRL_WRITE_ALL_MASK), the tracker state enum {IDLE, ACTIVE, END}, and the AW width function.
- Sub-module kf8237_access_tracker holds the state machine, abort flag and end strobe. It is instantiated for read and for write.

## Test plan
- CHANNELS=4: write offset 2 data 8'h34, then 8'h12 -> write_base_and_current_address=4'b0010 twice; access_high_byte 0 then 1; byte_pointer ends 0.
- CHANNELS=8: with current_word_count ch7 = 16'hBEEF, byte_pointer=0, read offset 15 twice -> data_bus_out 8'hEF then 8'hBE; byte_pointer toggles each read.
- Write control offset 5 with byte_pointer=1 -> master_clear one cycle; byte_pointer 0.
- Raise lock_bus_control mid-write at offset 8 -> no write_command_register strobe; byte_pointer unchanged; internal_data_bus still updated.
- Read offset 8 -> data_bus_out = status_register; read_status_done one cycle after io_read_n_in rises.
- Assert reset during an ACTIVE write -> no strobe follows; all outputs at reset values next cycle.

Source files
------------

// File: rtl/kf8237_bus_pkg.sv
// Shared definitions for the KF8237 host-bus front end: control offsets,
// access tracker states and the address width rule.
package kf8237_bus_pkg;

    localparam logic [2:0] CTRL_COMMAND        = 3'd0;
    localparam logic [2:0] CTRL_REQUEST        = 3'd1;
    localparam logic [2:0] CTRL_SINGLE_MASK    = 3'd2;
    localparam logic [2:0] CTRL_MODE           = 3'd3;
    localparam logic [2:0] CTRL_BYTE_POINTER   = 3'd4;
    localparam logic [2:0] CTRL_MASTER_CLEAR   = 3'd5;
    localparam logic [2:0] CTRL_CLEAR_MASK     = 3'd6;
    localparam logic [2:0] CTRL_WRITE_ALL_MASK = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        END    = 2'd2
    } tracker_state_t;

    // One MSB selects control space above the 2*CHANNELS channel offsets.
    function automatic int aw_for(input int channels);
        int w;
        w = $clog2(2 * channels);
        return ((w > 3) ? w : 3) + 1;
    endfunction

endpackage

// File: rtl/kf8237_access_tracker.sv
// Follows one CPU strobe through IDLE -> ACTIVE -> END, with a sticky abort
// raised by lock_bus_control, and flags the edge at which the access completes.
module kf8237_access_tracker
    import kf8237_bus_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic strobe_n,
    input  logic other_strobe_n,
    input  logic chip_select_n,
    input  logic lock_bus_control,
    output logic active_sample,
    output logic active,
    output logic complete
);

    tracker_state_t state, state_next;
    logic           abort, abort_next;
    logic           selected;

    // Both strobes low together is treated as no access at all.
    assign selected = ~strobe_n & ~chip_select_n & other_strobe_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            abort <= 1'b0;
        end else begin
            state <= state_next;
            abort <= abort_next;
        end
    end

    always_comb begin
        state_next = state;
        abort_next = abort;
        case (state)
            IDLE: begin
                if (selected) begin
                    state_next = ACTIVE;
                    abort_next = lock_bus_control;
                end
            end
            ACTIVE: begin
                abort_next = abort | lock_bus_control;
                if (!selected) state_next = END;
            end
            END: begin
                state_next = IDLE;
                abort_next = 1'b0;
            end
            default: begin
                state_next = IDLE;
                abort_next = 1'b0;
            end
        endcase
    end

    assign active_sample = selected & (state != END);
    assign active        = (state == ACTIVE) & ~abort;
    assign complete      = (state == ACTIVE) & ~selected & ~abort_next;

endmodule

// File: rtl/kf8237_bus_interface.sv
// CPU-side bus front end of the KF8237: tracks reads/writes, issues one-cycle
// register strobes, owns the byte pointer and drives registered read data.
module kf8237_bus_interface
    import kf8237_bus_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int AW       = aw_for(CHANNELS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    chip_select_n,
    input  logic                    io_read_n_in,
    input  logic                    io_write_n_in,
    input  logic [AW-1:0]           address_in,
    input  logic [7:0]              data_bus_in,
    input  logic                    lock_bus_control,
    input  logic [16*CHANNELS-1:0]  current_address,
    input  logic [16*CHANNELS-1:0]  current_word_count,
    input  logic [7:0]              status_register,
    input  logic [7:0]              temporary_register,
    output logic [7:0]              internal_data_bus,
    output logic                    write_command_register,
    output logic                    write_request_register,
    output logic                    set_or_reset_mask_register,
    output logic                    write_mode_register,
    output logic                    write_mask_register,
    output logic                    master_clear,
    output logic                    clear_mask_register,
    output logic [CHANNELS-1:0]     write_base_and_current_address,
    output logic [CHANNELS-1:0]     write_base_and_current_word_count,
    output logic                    access_high_byte,
    output logic                    byte_pointer,
    output logic                    read_status_done,
    output logic [7:0]              data_bus_out,
    output logic                    data_bus_out_enable
);

    logic                wr_sample, wr_active, wr_complete;
    logic                rd_sample, rd_active, rd_complete;
    logic [AW-1:0]       wr_addr, rd_addr;
    logic [CHANNELS-1:0] wr_addr_hot, wr_cnt_hot;
    logic                wr_channel, rd_channel;
    logic [15:0]         rd_word;
    logic [7:0]          rd_data;

    kf8237_access_tracker u_write_tracker (
        .clock            (clock),
        .reset            (reset),
        .strobe_n         (io_write_n_in),
        .other_strobe_n   (io_read_n_in),
        .chip_select_n    (chip_select_n),
        .lock_bus_control (lock_bus_control),
        .active_sample    (wr_sample),
        .active           (wr_active),
        .complete         (wr_complete)
    );

    kf8237_access_tracker u_read_tracker (
        .clock            (clock),
        .reset            (reset),
        .strobe_n         (io_read_n_in),
        .other_strobe_n   (io_write_n_in),
        .chip_select_n    (chip_select_n),
        .lock_bus_control (lock_bus_control),
        .active_sample    (rd_sample),
        .active           (rd_active),
        .complete         (rd_complete)
    );

    assign data_bus_out_enable = rd_active & ~wr_active;

    always_comb begin
        wr_addr_hot = '0;
        wr_cnt_hot  = '0;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            if (!wr_addr[AW-1] && int'(wr_addr[AW-2:1]) == int'(n)) begin
                if (wr_addr[0]) wr_cnt_hot[n]  = 1'b1;
                else            wr_addr_hot[n] = 1'b1;
            end
        end
    end

    assign wr_channel = |{wr_addr_hot, wr_cnt_hot};
    assign rd_channel = !rd_addr[AW-1] && (int'(rd_addr[AW-2:1]) < CHANNELS);

    // Read data is selected from the live address so it is valid one cycle in.
    always_comb begin
        rd_word = '0;
        rd_data = 8'hFF;
        if (!address_in[AW-1]) begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                if (int'(address_in[AW-2:1]) == int'(n)) begin
                    rd_word = address_in[0] ? current_word_count[16*n +: 16]
                                            : current_address[16*n +: 16];
                    rd_data = byte_pointer ? rd_word[15:8] : rd_word[7:0];
                end
            end
        end else begin
            case (address_in[2:0])
                CTRL_COMMAND:      rd_data = status_register;
                CTRL_MASTER_CLEAR: rd_data = temporary_register;
                default:           rd_data = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            internal_data_bus                 <= 8'h00;
            wr_addr                           <= '0;
            rd_addr                           <= '0;
            data_bus_out                      <= 8'hFF;
            byte_pointer                      <= 1'b0;
            access_high_byte                  <= 1'b0;
            write_command_register            <= 1'b0;
            write_request_register            <= 1'b0;
            set_or_reset_mask_register        <= 1'b0;
            write_mode_register               <= 1'b0;
            write_mask_register               <= 1'b0;
            master_clear                      <= 1'b0;
            clear_mask_register               <= 1'b0;
            write_base_and_current_address    <= '0;
            write_base_and_current_word_count <= '0;
            read_status_done                  <= 1'b0;
        end else begin
            write_command_register            <= 1'b0;
            write_request_register            <= 1'b0;
            set_or_reset_mask_register        <= 1'b0;
            write_mode_register               <= 1'b0;
            write_mask_register               <= 1'b0;
            master_clear                      <= 1'b0;
            clear_mask_register               <= 1'b0;
            write_base_and_current_address    <= '0;
            write_base_and_current_word_count <= '0;
            read_status_done                  <= 1'b0;

            if (wr_sample) begin
                wr_addr           <= address_in;
                internal_data_bus <= data_bus_in;
            end
            if (rd_sample) begin
                rd_addr      <= address_in;
                data_bus_out <= rd_data;
            end

            if (wr_complete) begin
                access_high_byte <= byte_pointer;
                if (!wr_addr[AW-1]) begin
                    write_base_and_current_address    <= wr_addr_hot;
                    write_base_and_current_word_count <= wr_cnt_hot;
                    if (wr_channel) byte_pointer <= ~byte_pointer;
                end else begin
                    case (wr_addr[2:0])
                        CTRL_COMMAND:        write_command_register     <= 1'b1;
                        CTRL_REQUEST:        write_request_register     <= 1'b1;
                        CTRL_SINGLE_MASK:    set_or_reset_mask_register <= 1'b1;
                        CTRL_MODE:           write_mode_register        <= 1'b1;
                        CTRL_BYTE_POINTER:   byte_pointer               <= 1'b0;
                        CTRL_MASTER_CLEAR: begin
                            master_clear <= 1'b1;
                            byte_pointer <= 1'b0;
                        end
                        CTRL_CLEAR_MASK:     clear_mask_register        <= 1'b1;
                        CTRL_WRITE_ALL_MASK: write_mask_register        <= 1'b1;
                        default: ;
                    endcase
                end
            end

            if (rd_complete) begin
                access_high_byte <= byte_pointer;
                if (rd_channel) begin
                    byte_pointer <= ~byte_pointer;
                end else if (rd_addr[AW-1]) begin
                    if (rd_addr[2:0] == CTRL_BYTE_POINTER) byte_pointer     <= 1'b1;
                    if (rd_addr[2:0] == CTRL_COMMAND)      read_status_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_kf8237_bus_interface.sv
// Randomised and directed bench for kf8237_bus_interface, run on a 4-channel
// and a 3-channel instance sharing the same CPU bus stimulus.
module tb_kf8237_bus_interface;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        chip_select_n = 1'b1;
    logic        io_read_n_in = 1'b1;
    logic        io_write_n_in = 1'b1;
    logic [3:0]  address_in = '0;
    logic [7:0]  data_bus_in = '0;
    logic        lock_bus_control = 1'b0;
    logic [63:0] cur_addr = '0;
    logic [63:0] cur_cnt = '0;
    logic [7:0]  status_register = '0;
    logic [7:0]  temporary_register = '0;

    logic [7:0] idb4, dbo4, idb3, dbo3;
    logic wcr4, wrr4, sorm4, wmode4, wmask4, mc4, cmr4, ahb4, bp4, rsd4, dbe4;
    logic wcr3, wrr3, sorm3, wmode3, wmask3, mc3, cmr3, ahb3, bp3, rsd3, dbe3;
    logic [3:0] wa4, wc4;
    logic [2:0] wa3, wc3;
    logic [14:0] obs4, obs3;

    int checks = 0;
    int failures = 0;
    logic m_bp4 = 1'b0, m_bp3 = 1'b0, m_ahb4 = 1'b0;

    always #5 clock = ~clock;

    kf8237_bus_interface #(.CHANNELS(4)) dut4 (
        .clock(clock), .reset(reset), .chip_select_n(chip_select_n),
        .io_read_n_in(io_read_n_in), .io_write_n_in(io_write_n_in),
        .address_in(address_in), .data_bus_in(data_bus_in),
        .lock_bus_control(lock_bus_control), .current_address(cur_addr),
        .current_word_count(cur_cnt), .status_register(status_register),
        .temporary_register(temporary_register), .internal_data_bus(idb4),
        .write_command_register(wcr4), .write_request_register(wrr4),
        .set_or_reset_mask_register(sorm4), .write_mode_register(wmode4),
        .write_mask_register(wmask4), .master_clear(mc4),
        .clear_mask_register(cmr4), .write_base_and_current_address(wa4),
        .write_base_and_current_word_count(wc4), .access_high_byte(ahb4),
        .byte_pointer(bp4), .read_status_done(rsd4), .data_bus_out(dbo4),
        .data_bus_out_enable(dbe4)
    );

    kf8237_bus_interface #(.CHANNELS(3)) dut3 (
        .clock(clock), .reset(reset), .chip_select_n(chip_select_n),
        .io_read_n_in(io_read_n_in), .io_write_n_in(io_write_n_in),
        .address_in(address_in), .data_bus_in(data_bus_in),
        .lock_bus_control(lock_bus_control), .current_address(cur_addr[47:0]),
        .current_word_count(cur_cnt[47:0]), .status_register(status_register),
        .temporary_register(temporary_register), .internal_data_bus(idb3),
        .write_command_register(wcr3), .write_request_register(wrr3),
        .set_or_reset_mask_register(sorm3), .write_mode_register(wmode3),
        .write_mask_register(wmask3), .master_clear(mc3),
        .clear_mask_register(cmr3), .write_base_and_current_address(wa3),
        .write_base_and_current_word_count(wc3), .access_high_byte(ahb3),
        .byte_pointer(bp3), .read_status_done(rsd3), .data_bus_out(dbo3),
        .data_bus_out_enable(dbe3)
    );

    // Bit order {cmd,req,single_mask,mode,all_mask,master_clear,clear_mask,addr[3:0],count[3:0]}
    assign obs4 = {wcr4, wrr4, sorm4, wmode4, wmask4, mc4, cmr4, wa4, wc4};
    assign obs3 = {wcr3, wrr3, sorm3, wmode3, wmask3, mc3, cmr3, 1'b0, wa3, 1'b0, wc3};

    function automatic logic [14:0] exp_wr(input int a, input int ch);
        logic [14:0] v;
        v = '0;
        if (a < 8) begin
            if (a / 2 < ch) begin
                if (a % 2 == 0) v[4 + a / 2] = 1'b1;
                else            v[a / 2]     = 1'b1;
            end
        end else begin
            case (a - 8)
                0: v[14] = 1'b1;
                1: v[13] = 1'b1;
                2: v[12] = 1'b1;
                3: v[11] = 1'b1;
                5: v[9]  = 1'b1;
                6: v[8]  = 1'b1;
                7: v[10] = 1'b1;
                default: ;
            endcase
        end
        return v;
    endfunction

    function automatic logic bp_after_write(input int a, input int ch, input logic bp, input logic ab);
        if (ab) return bp;
        if (a < 8 && a / 2 < ch) return ~bp;
        if (a == 12 || a == 13) return 1'b0;
        return bp;
    endfunction

    function automatic logic bp_after_read(input int a, input int ch, input logic bp, input logic ab);
        if (ab) return bp;
        if (a < 8 && a / 2 < ch) return ~bp;
        if (a == 12) return 1'b1;
        return bp;
    endfunction

    function automatic logic [7:0] rd_expect(input int a, input int ch, input logic bp);
        logic [15:0] w;
        if (a < 8) begin
            if (a / 2 >= ch) return 8'hFF;
            w = (a % 2 == 1) ? cur_cnt[16 * (a / 2) +: 16] : cur_addr[16 * (a / 2) +: 16];
            return bp ? w[15:8] : w[7:0];
        end
        if (a == 8)  return status_register;
        if (a == 13) return temporary_register;
        return 8'hFF;
    endfunction

    // lock_at: -1 for no lock, else the sample index (0..n) at which lock is high
    task automatic write_access(input int a, input logic [7:0] d, input int n, input int lock_at);
        logic ab, nb4, nb3;
        logic [14:0] e4, e3;
        ab = (lock_at >= 0 && lock_at <= n);
        @(negedge clock);
        chip_select_n = 1'b0; io_write_n_in = 1'b0; address_in = 4'(a); data_bus_in = d;
        for (int i = 0; i < n; i++) begin
            lock_bus_control = (i == lock_at);
            @(negedge clock);
        end
        io_write_n_in = 1'b1; chip_select_n = 1'b1; lock_bus_control = (lock_at == n);
        @(negedge clock);
        lock_bus_control = 1'b0;
        e4 = ab ? 15'd0 : exp_wr(a, 4);
        e3 = ab ? 15'd0 : exp_wr(a, 3);
        nb4 = bp_after_write(a, 4, m_bp4, ab);
        nb3 = bp_after_write(a, 3, m_bp3, ab);
        if (!ab) m_ahb4 = m_bp4;
        checks++; if (obs4 !== e4) begin failures++; $display("FAIL wr_strobe4 a=%0d got=%h exp=%h", a, obs4, e4); end
        checks++; if (obs3 !== e3) begin failures++; $display("FAIL wr_strobe3 a=%0d got=%h exp=%h", a, obs3, e3); end
        checks++; if (bp4 !== nb4) begin failures++; $display("FAIL wr_bp4 a=%0d got=%b exp=%b", a, bp4, nb4); end
        checks++; if (bp3 !== nb3) begin failures++; $display("FAIL wr_bp3 a=%0d got=%b exp=%b", a, bp3, nb3); end
        checks++; if (ahb4 !== m_ahb4) begin failures++; $display("FAIL wr_ahb4 a=%0d got=%b exp=%b", a, ahb4, m_ahb4); end
        checks++; if (idb4 !== d) begin failures++; $display("FAIL wr_idb4 a=%0d got=%h exp=%h", a, idb4, d); end
        m_bp4 = nb4; m_bp3 = nb3;
        @(negedge clock);
        checks++; if (obs4 !== 15'd0 || obs3 !== 15'd0) begin
            failures++; $display("FAIL wr_single_cycle a=%0d got4=%h got3=%h exp=0", a, obs4, obs3);
        end
    endtask

    // lock_at: -1 for no lock, else 1..n
    task automatic read_access(input int a, input int n, input int lock_at);
        logic ab, nb4, nb3;
        logic [7:0] e4, e3;
        ab = (lock_at >= 1);
        e4 = rd_expect(a, 4, m_bp4);
        e3 = rd_expect(a, 3, m_bp3);
        @(negedge clock);
        chip_select_n = 1'b0; io_read_n_in = 1'b0; address_in = 4'(a);
        @(negedge clock);
        checks++; if (dbo4 !== e4) begin failures++; $display("FAIL rd_data4 a=%0d got=%h exp=%h", a, dbo4, e4); end
        checks++; if (dbo3 !== e3) begin failures++; $display("FAIL rd_data3 a=%0d got=%h exp=%h", a, dbo3, e3); end
        checks++; if (dbe4 !== 1'b1) begin failures++; $display("FAIL rd_enable a=%0d got=%b exp=1", a, dbe4); end
        for (int i = 1; i < n; i++) begin
            lock_bus_control = (i == lock_at);
            @(negedge clock);
        end
        io_read_n_in = 1'b1; chip_select_n = 1'b1; lock_bus_control = (lock_at == n);
        @(negedge clock);
        lock_bus_control = 1'b0;
        nb4 = bp_after_read(a, 4, m_bp4, ab);
        nb3 = bp_after_read(a, 3, m_bp3, ab);
        checks++; if (rsd4 !== (!ab && a == 8)) begin failures++; $display("FAIL rd_status_done4 a=%0d got=%b exp=%b", a, rsd4, (!ab && a == 8)); end
        checks++; if (rsd3 !== (!ab && a == 8)) begin failures++; $display("FAIL rd_status_done3 a=%0d got=%b exp=%b", a, rsd3, (!ab && a == 8)); end
        checks++; if (bp4 !== nb4) begin failures++; $display("FAIL rd_bp4 a=%0d got=%b exp=%b", a, bp4, nb4); end
        checks++; if (bp3 !== nb3) begin failures++; $display("FAIL rd_bp3 a=%0d got=%b exp=%b", a, bp3, nb3); end
        checks++; if (dbe4 !== 1'b0) begin failures++; $display("FAIL rd_enable_end a=%0d got=%b exp=0", a, dbe4); end
        if (!ab) m_ahb4 = m_bp4;
        m_bp4 = nb4; m_bp3 = nb3;
        @(negedge clock);
        checks++; if (rsd4 !== 1'b0) begin failures++; $display("FAIL rd_status_single a=%0d got=%b exp=0", a, rsd4); end
    endtask

    task automatic check_reset_values(input string tag);
        checks++; if (obs4 !== 15'd0 || rsd4 !== 1'b0) begin failures++; $display("FAIL %s_strobes got=%h/%b exp=0", tag, obs4, rsd4); end
        checks++; if (idb4 !== 8'h00) begin failures++; $display("FAIL %s_idb got=%h exp=00", tag, idb4); end
        checks++; if (bp4 !== 1'b0 || ahb4 !== 1'b0) begin failures++; $display("FAIL %s_pointer got=%b/%b exp=0/0", tag, bp4, ahb4); end
        checks++; if (dbo4 !== 8'hFF) begin failures++; $display("FAIL %s_dbo got=%h exp=FF", tag, dbo4); end
        checks++; if (dbe4 !== 1'b0) begin failures++; $display("FAIL %s_dbe got=%b exp=0", tag, dbe4); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b0;
        m_bp4 = 1'b0; m_bp3 = 1'b0; m_ahb4 = 1'b0;
    endtask

    task automatic test_channel_write();
        write_access(2, 8'h34, 1, -1);
        write_access(2, 8'h12, 2, -1);
        checks++; if (bp4 !== 1'b0) begin failures++; $display("FAIL chwr_bp_final got=%b exp=0", bp4); end
    endtask

    task automatic test_channel_read();
        cur_cnt[63:48] = 16'hBEEF;
        read_access(7, 1, -1);
        checks++; if (dbo4 !== 8'hEF) begin failures++; $display("FAIL chrd_low got=%h exp=EF", dbo4); end
        read_access(7, 2, -1);
        checks++; if (dbo4 !== 8'hBE) begin failures++; $display("FAIL chrd_high got=%h exp=BE", dbo4); end
    endtask

    task automatic test_master_clear();
        read_access(12, 1, -1);
        write_access(13, 8'h5A, 1, -1);
        checks++; if (bp4 !== 1'b0) begin failures++; $display("FAIL mclr_bp got=%b exp=0", bp4); end
    endtask

    task automatic test_lock_abort();
        read_access(12, 1, -1);
        write_access(8, 8'hC3, 3, 1);
        read_access(0, 3, 2);
    endtask

    task automatic test_status_read();
        status_register = 8'hA5;
        read_access(8, 2, -1);
    endtask

    task automatic test_unused_channel();
        write_access(6, 8'h66, 1, -1);
        write_access(7, 8'h77, 1, -1);
        read_access(6, 1, -1);
        read_access(7, 1, -1);
    endtask

    task automatic test_random();
        int a, n, lk;
        for (int k = 0; k < 60; k++) begin
            a = int'($urandom_range(0, 15));
            n = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) begin
                lk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
                write_access(a, 8'($urandom), n, lk);
            end else begin
                lk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : -1;
                read_access(a, n, lk);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clock);
        chip_select_n = 1'b0; io_write_n_in = 1'b0; address_in = 4'd2; data_bus_in = 8'hAA;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("midreset");
        reset = 1'b0; io_write_n_in = 1'b1; chip_select_n = 1'b1;
        m_bp4 = 1'b0; m_bp3 = 1'b0; m_ahb4 = 1'b0;
        repeat (2) begin
            @(negedge clock);
            checks++; if (obs4 !== 15'd0) begin failures++; $display("FAIL midreset_no_strobe got=%h exp=0", obs4); end
        end
        write_access(3, 8'h01, 1, -1);
    endtask

    initial begin
        cur_addr = {$urandom, $urandom};
        cur_cnt  = {$urandom, $urandom};
        status_register    = 8'($urandom);
        temporary_register = 8'($urandom);
        test_reset();
        test_channel_write();
        test_channel_read();
        test_master_clear();
        test_lock_abort();
        test_status_read();
        test_unused_channel();
        test_random();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
